wbu: RTL and testbench

//  Writeback stage: single-entry pipeline register between the LSU stage and the integer regfile.

---
 rtl/liang_pkg.sv | 22 ++
 rtl/wbu_load_ext.sv | 21 ++
 rtl/wbu.sv | 78 +++++++
 tb/tb_wbu.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/liang_pkg.sv
// liang_pkg: shared writeback-stage types (load opcodes, pipeline entry layout).
package liang_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_op_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rd;
        logic              rd_wen;
        logic [XLEN-1:0]   wdata;
    } wb_entry_t;

endpackage

// File: rtl/wbu_load_ext.sv
// load_ext: selects the addressed byte/half of a raw load word and sign-/zero-extends it.
module load_ext import liang_pkg::*; #(
    parameter int W = XLEN
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   addr_lo,
    input  logic [W-1:0] word,
    output logic [W-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b    = word[{addr_lo, 3'b000} +: 8];
        h    = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
        // LW and the unassigned encodings fall through to the raw word
        data = funct3 == LB  ? {{(W-8){b[7]}}, b}   :
               funct3 == LBU ? {{(W-8){1'b0}}, b}   :
               funct3 == LH  ? {{(W-16){h[15]}}, h} :
               funct3 == LHU ? {{(W-16){1'b0}}, h}  : word;
    end
endmodule

// File: rtl/wbu.sv
// wbu: single-entry writeback register between LSU and regfile; commits one result per handshake.
// Define WBU_INSTRET_EN to add a 64-bit retired-instruction counter port (instret).
module wbu import liang_pkg::*; #(
    parameter int ADDR_WIDTH = REG_AW,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_result,
    output logic                  cm_valid,
    input  logic                  cm_ready,
    output logic [DATA_WIDTH-1:0] cm_pc,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  pend_valid,
    output logic [ADDR_WIDTH-1:0] pend_rd
`ifdef WBU_INSTRET_EN
    ,
    output logic [63:0]           instret
`endif
);
    wb_entry_t             q;
    logic                  full;
    logic                  in_fire;
    logic                  cm_fire;
    logic                  writes_rd;
    logic [DATA_WIDTH-1:0] ext;

    load_ext #(.W(DATA_WIDTH)) u_load_ext (
        .funct3 (in_funct3),
        .addr_lo(in_addr_lo),
        .word   (in_result),
        .data   (ext)
    );

    // Masking with rst keeps a held entry from committing in the reset cycle itself
    assign cm_valid   = full & !rst;
    assign cm_fire    = cm_valid & cm_ready;
    assign in_ready   = !cm_valid | cm_fire;
    assign in_fire    = in_valid & in_ready;
    assign writes_rd  = q.rd_wen & (q.rd != '0);
    assign cm_pc      = q.pc;
    assign rf_wen     = cm_fire & writes_rd;
    assign rf_waddr   = q.rd;
    assign rf_wdata   = q.wdata;
    assign pend_valid = cm_valid & writes_rd;
    assign pend_rd    = pend_valid ? q.rd : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else begin
            full <= in_fire | (full & !cm_fire);
            if (in_fire)
                q <= '{pc: in_pc, rd: in_rd, rd_wen: in_rd_wen,
                       wdata: in_is_load ? ext : in_result};
        end
    end

`ifdef WBU_INSTRET_EN
    always_ff @(posedge clk) begin
        if (rst)
            instret <= '0;
        else if (cm_fire)
            instret <= instret + 64'd1;
    end
`endif
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: randomized self-checking bench for wbu against a behavioural writeback model.
module tb_wbu;
    logic        clk, rst;
    logic        in_valid, in_ready, in_rd_wen, in_is_load;
    logic [31:0] in_pc, in_result;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        cm_valid, cm_ready, rf_wen, pend_valid;
    logic [31:0] cm_pc, rf_wdata;
    logic [4:0]  rf_waddr, pend_rd;
`ifdef WBU_INSTRET_EN
    logic [63:0] instret;
`endif
    int total = 0;
    int bad   = 0;

    wbu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .in_result(in_result), .cm_valid(cm_valid), .cm_ready(cm_ready),
        .cm_pc(cm_pc), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_valid(pend_valid), .pend_rd(pend_rd)
`ifdef WBU_INSTRET_EN
        , .instret(instret)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Architectural meaning of a RISC-V load: pick the addressed byte/half and extend it
    function automatic logic [31:0] ref_ext(input logic isl, input logic [2:0] f3,
                                            input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] sh;
        if (!isl) return w;
        case (f3)
            3'd0: begin sh = w >> (8 * lo); return int'($signed(sh[7:0])); end
            3'd4: return (w >> (8 * lo)) & 32'hFF;
            3'd1: begin sh = w >> (16 * lo[1]); return int'($signed(sh[15:0])); end
            3'd5: return (w >> (16 * lo[1])) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic wen, input logic isl, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] res);
        in_valid = v; in_pc = pc; in_rd = rd; in_rd_wen = wen;
        in_is_load = isl; in_funct3 = f3; in_addr_lo = lo; in_result = res;
    endtask

    task automatic test_reset();
        rst = 1; cm_ready = 0;
        drive(1, 32'h44, 5'd3, 1, 0, 0, 0, 32'hDEAD);
        tick(); tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (cm_valid !== 1'b0) begin bad++; $display("FAIL reset_cm_valid got=%b exp=0", cm_valid); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen got=%b exp=0", rf_wen); end
        total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL reset_pend_valid got=%b exp=0", pend_valid); end
        total++; if ({cm_pc, rf_waddr, rf_wdata, pend_rd} !== '0) begin bad++; $display("FAIL reset_zero_outputs got=%h exp=0", {cm_pc, rf_waddr, rf_wdata, pend_rd}); end
        rst = 0; in_valid = 0;
        tick();
    endtask

    task automatic test_alu();
        cm_ready = 1;
        drive(1, 32'h1000, 5'd5, 1, 0, 0, 0, 32'h1234);
        tick();
        in_valid = 0;
        total++; if (cm_valid !== 1'b1) begin bad++; $display("FAIL alu_cm_valid got=%b exp=1", cm_valid); end
        total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL alu_rf_wen got=%b exp=1", rf_wen); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0d exp=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL alu_wdata got=%h exp=1234", rf_wdata); end
        total++; if (pend_valid !== 1'b1 || pend_rd !== 5'd5) begin bad++; $display("FAIL alu_pend got=%b/%0d exp=1/5", pend_valid, pend_rd); end
        total++; if (cm_pc !== 32'h1000) begin bad++; $display("FAIL alu_cm_pc got=%h exp=1000", cm_pc); end
        tick();
        total++; if (cm_valid !== 1'b0 || pend_valid !== 1'b0 || pend_rd !== 5'd0) begin bad++; $display("FAIL alu_drain got=%b/%b/%0d exp=0/0/0", cm_valid, pend_valid, pend_rd); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3[6]  = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd3};
        logic [1:0]  lo[6]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
        logic [31:0] exp[6] = '{32'hFFFFFF80, 32'h7F, 32'hFFFF80FF, 32'h7F01, 32'h80FF7F01, 32'h80FF7F01};
        cm_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h2000 + i * 4, 5'd10, 1, 1, f3[i], lo[i], 32'h80FF7F01);
            tick();
            in_valid = 0;
            total++; if (rf_wdata !== exp[i]) begin bad++; $display("FAIL load_ext_%0d got=%h exp=%h", i, rf_wdata, exp[i]); end
            tick();
        end
    endtask

    task automatic test_x0();
        cm_ready = 0;
        drive(1, 32'h3000, 5'd0, 1, 0, 0, 0, 32'hCAFE);
        tick();
        in_valid = 0;
        total++; if (cm_valid !== 1'b1) begin bad++; $display("FAIL x0_cm_valid got=%b exp=1", cm_valid); end
        total++; if (pend_valid !== 1'b0 || pend_rd !== 5'd0) begin bad++; $display("FAIL x0_pend got=%b/%0d exp=0/0", pend_valid, pend_rd); end
        cm_ready = 1;
        #1;
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_rf_wen got=%b exp=0", rf_wen); end
        tick();
    endtask

    task automatic test_stall();
        cm_ready = 0;
        drive(1, 32'h100, 5'd7, 1, 0, 0, 0, 32'hAAAA0001);
        tick();
        drive(1, 32'h104, 5'd9, 1, 0, 0, 0, 32'h5555);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0 || rf_wen !== 1'b0) begin bad++; $display("FAIL stall_hold_%0d got=ready %b wen %b exp=0/0", i, in_ready, rf_wen); end
            total++; if (cm_valid !== 1'b1 || cm_pc !== 32'h100 || rf_wdata !== 32'hAAAA0001 || pend_rd !== 5'd7) begin bad++; $display("FAIL stall_stable_%0d got=%b %h %h %0d exp=1 100 aaaa0001 7", i, cm_valid, cm_pc, rf_wdata, pend_rd); end
            tick();
        end
        cm_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1 || rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin bad++; $display("FAIL stall_release got=%b %b %0d exp=1 1 7", in_ready, rf_wen, rf_waddr); end
        tick();
        in_valid = 0;
        total++; if (cm_valid !== 1'b1 || cm_pc !== 32'h104 || rf_wdata !== 32'h5555) begin bad++; $display("FAIL stall_next got=%b %h %h exp=1 104 5555", cm_valid, cm_pc, rf_wdata); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp[10];
        int commits = 0;
        rst = 1; in_valid = 0; cm_ready = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 10; i++) begin
            exp[i] = $urandom;
            drive(1, 32'h4000 + i * 4, 5'($urandom_range(1, 31)), 1, 0, 0, 0, exp[i]);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready); end
            if (i > 0) begin
                total++; if (rf_wen !== 1'b1 || rf_wdata !== exp[i-1]) begin bad++; $display("FAIL b2b_commit_%0d got=%b %h exp=1 %h", i - 1, rf_wen, rf_wdata, exp[i-1]); end
            end
            commits += int'(rf_wen);
            tick();
        end
        in_valid = 0;
        #1;
        total++; if (rf_wen !== 1'b1 || rf_wdata !== exp[9]) begin bad++; $display("FAIL b2b_commit_9 got=%b %h exp=1 %h", rf_wen, rf_wdata, exp[9]); end
        commits += int'(rf_wen);
        tick();
        total++; if (commits !== 10) begin bad++; $display("FAIL b2b_count got=%0d exp=10", commits); end
`ifdef WBU_INSTRET_EN
        total++; if (instret !== 64'd10) begin bad++; $display("FAIL b2b_instret got=%0d exp=10", instret); end
`endif
    endtask

    task automatic test_mid_reset();
        cm_ready = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000 + i * 4, 5'd12, 1, 0, 0, 0, 32'h77 + i);
            tick();
        end
        rst = 1;
        #1;
        total++; if (rf_wen !== 1'b0 || cm_valid !== 1'b0) begin bad++; $display("FAIL midrst_during got=%b/%b exp=0/0", rf_wen, cm_valid); end
        tick();
        rst = 0; in_valid = 0;
        #1;
        total++; if (cm_valid !== 1'b0 || rf_wen !== 1'b0 || pend_valid !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b/%b/%b exp=0/0/0", cm_valid, rf_wen, pend_valid); end
        total++; if (cm_pc !== 32'd0 || rf_wdata !== 32'd0) begin bad++; $display("FAIL midrst_zero got=%h/%h exp=0/0", cm_pc, rf_wdata); end
`ifdef WBU_INSTRET_EN
        total++; if (instret !== 64'd0) begin bad++; $display("FAIL midrst_instret got=%0d exp=0", instret); end
`endif
        tick();
    endtask

    task automatic test_random();
        logic        m_full = 0, m_wen = 0;
        logic [31:0] m_pc = 0, m_wdata = 0;
        logic [4:0]  m_rd = 0;
        logic        cf, ir, pend;
        rst = 1; in_valid = 0;
        tick();
        rst = 0;
        for (int i = 0; i < 300; i++) begin
            cm_ready = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0, $urandom, 5'($urandom % 32), 1'($urandom), 1'($urandom),
                  3'($urandom), 2'($urandom), $urandom);
            #1;
            cf   = m_full & cm_ready;
            ir   = !m_full | cf;
            pend = m_full & m_wen & (m_rd != 0);
            total++; if (in_ready !== ir || cm_valid !== m_full) begin bad++; $display("FAIL rand_hs_%0d got=%b/%b exp=%b/%b", i, in_ready, cm_valid, ir, m_full); end
            total++; if (rf_wen !== (cf & pend)) begin bad++; $display("FAIL rand_wen_%0d got=%b exp=%b", i, rf_wen, cf & pend); end
            total++; if (pend_valid !== pend || pend_rd !== (pend ? m_rd : 5'd0)) begin bad++; $display("FAIL rand_pend_%0d got=%b/%0d exp=%b/%0d", i, pend_valid, pend_rd, pend, pend ? m_rd : 5'd0); end
            if (m_full) begin
                total++; if (cm_pc !== m_pc || rf_waddr !== m_rd || rf_wdata !== m_wdata) begin bad++; $display("FAIL rand_data_%0d got=%h %0d %h exp=%h %0d %h", i, cm_pc, rf_waddr, rf_wdata, m_pc, m_rd, m_wdata); end
            end
            if (in_valid && ir) begin
                m_full = 1; m_pc = in_pc; m_rd = in_rd; m_wen = in_rd_wen;
                m_wdata = ref_ext(in_is_load, in_funct3, in_addr_lo, in_result);
            end else if (cf) m_full = 0;
            tick();
        end
        in_valid = 0; cm_ready = 1;
        tick();
    endtask

    initial begin
        rst = 1; cm_ready = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu();
        test_load_ext();
        test_x0();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
